// File: rtl/dqn_ctrl_pkg.sv
// Shared control definitions for the DQN training datapath: sequencer state
// encoding, layer-operation codes on the ctrl bus, and common bus widths.
// Imported by the update sequencer and by every layer parameter block.
package dqn_ctrl_pkg;

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_WAIT,
    ST_UPD3,
    ST_UPD2,
    ST_UPD1,
    ST_DONE
  } seq_state_t;

  // Layer-operation codes; a parameter block updates only when step != 0
  // and ctrl matches its own layer code.
  localparam logic [CTRL_W-1:0] CTRL_IDLE = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_FWD  = 4'b0100;
  localparam logic [CTRL_W-1:0] CTRL_WAIT = 4'b0101;
  localparam logic [CTRL_W-1:0] CTRL_UPD1 = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_UPD2 = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_UPD3 = 4'b0011;

  // ctrl code presented while the sequencer is in a given state
  function automatic logic [CTRL_W-1:0] ctrl_of(seq_state_t s);
    logic [CTRL_W-1:0] c;
    c = CTRL_IDLE;
    case (s)
      ST_FWD:  c = CTRL_FWD;
      ST_WAIT: c = CTRL_WAIT;
      ST_UPD3: c = CTRL_UPD3;
      ST_UPD2: c = CTRL_UPD2;
      ST_UPD1: c = CTRL_UPD1;
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sat_down_counter.sv
// Loadable down counter that saturates at zero.
// Ports: clk, rst_n (async active-low), load/load_val (load has priority),
// en (decrement when nonzero), zero_c (count is zero, decoded from the register).
module sat_down_counter
  import dqn_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_c
);

  logic [W-1:0] count;

  // count register: load wins over decrement, never wraps below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/dqn_update_sequencer.sv
// Sequences one DQN training run: per iteration a forward pass, a bounded wait
// for the gradient unit's deltas, then one-cycle update strobes to layers 3, 2, 1.
// Ports: clk, rst_n, start, abort, delta_valid in; ctrl[3:0], step[3:0], fwd_en,
// delta_req, busy, done, err out. All outputs are registered (Moore, decoded
// from the next state so they change together with the state register).
module dqn_update_sequencer
  import dqn_ctrl_pkg::*;
#(
  parameter int unsigned N_STEPS       = 10,
  parameter int unsigned FWD_CYCLES    = 4,
  parameter int unsigned DELTA_TIMEOUT = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              delta_valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [STEP_W-1:0] step,
  output logic              fwd_en,
  output logic              delta_req,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // step is 4 bits wide and must never wrap
  if (N_STEPS == 0 || N_STEPS > 15) begin : g_bad_n_steps
    $error("dqn_update_sequencer: N_STEPS must be in 1..15");
  end
  if (FWD_CYCLES == 0 || FWD_CYCLES > 255) begin : g_bad_fwd_cycles
    $error("dqn_update_sequencer: FWD_CYCLES must be in 1..255");
  end
  if (DELTA_TIMEOUT == 0 || DELTA_TIMEOUT > 255) begin : g_bad_delta_timeout
    $error("dqn_update_sequencer: DELTA_TIMEOUT must be in 1..255");
  end

  // counters are loaded with (length - 1) so the zero flag marks the last cycle
  localparam logic [CNT_W-1:0] FWD_LOAD  = CNT_W'(FWD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(DELTA_TIMEOUT - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS);

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [STEP_W-1:0] step_nxt;
  logic              err_nxt;
  logic              fwd_load;
  logic              fwd_dec;
  logic              fwd_zero_c;
  logic              wait_load;
  logic              wait_dec;
  logic              wait_zero_c;

  sat_down_counter #(.W(CNT_W)) u_fwd_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (fwd_load),
    .load_val (FWD_LOAD),
    .en       (fwd_dec),
    .zero_c   (fwd_zero_c)
  );

  sat_down_counter #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wait_load),
    .load_val (WAIT_LOAD),
    .en       (wait_dec),
    .zero_c   (wait_zero_c)
  );

  // next-state, step/err update and counter control
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    err_nxt   = err;
    fwd_load  = 1'b0;
    fwd_dec   = 1'b0;
    wait_load = 1'b0;
    wait_dec  = 1'b0;
    if (state != ST_IDLE && abort) begin
      // abort outranks everything, including a same-cycle timeout
      state_nxt = ST_IDLE;
      step_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state_nxt = ST_FWD;
            step_nxt  = STEP_W'(1);
            err_nxt   = 1'b0;
            fwd_load  = 1'b1;
          end
        end
        ST_FWD: begin
          if (fwd_zero_c) begin
            state_nxt = ST_WAIT;
            wait_load = 1'b1;
          end else begin
            fwd_dec = 1'b1;
          end
        end
        ST_WAIT: begin
          // a delta_valid on the timeout cycle still counts
          if (delta_valid) begin
            state_nxt = ST_UPD3;
          end else if (wait_zero_c) begin
            state_nxt = ST_IDLE;
            step_nxt  = '0;
            err_nxt   = 1'b1;
          end else begin
            wait_dec = 1'b1;
          end
        end
        ST_UPD3: state_nxt = ST_UPD2;
        ST_UPD2: state_nxt = ST_UPD1;
        ST_UPD1: begin
          if (step == LAST_STEP) begin
            state_nxt = ST_DONE;
            step_nxt  = '0;
          end else begin
            state_nxt = ST_FWD;
            step_nxt  = step + STEP_W'(1);
            fwd_load  = 1'b1;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: begin
          state_nxt = ST_IDLE;
          step_nxt  = '0;
        end
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      step      <= '0;
      err       <= 1'b0;
      ctrl      <= CTRL_IDLE;
      fwd_en    <= 1'b0;
      delta_req <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      step      <= step_nxt;
      err       <= err_nxt;
      ctrl      <= ctrl_of(state_nxt);
      fwd_en    <= (state_nxt == ST_FWD);
      delta_req <= (state_nxt == ST_WAIT);
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_dqn_update_sequencer.sv
// Self-checking bench for dqn_update_sequencer. Two instances: A (N_STEPS=2,
// FWD_CYCLES=4, DELTA_TIMEOUT=5) and B (N_STEPS=15, FWD_CYCLES=4,
// DELTA_TIMEOUT=200). Each run is expanded up front into a per-cycle list of
// inputs and expected outputs from the run's phase lengths; one loop drives
// and checks that list cycle by cycle.
module tb_dqn_update_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_start, a_abort, a_dv;
  logic [3:0] a_ctrl, a_step;
  logic       a_fwd, a_req, a_busy, a_done, a_err;
  logic       b_start, b_abort, b_dv;
  logic [3:0] b_ctrl, b_step;
  logic       b_fwd, b_req, b_busy, b_done, b_err;

  dqn_update_sequencer #(.N_STEPS(2), .FWD_CYCLES(4), .DELTA_TIMEOUT(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .delta_valid(a_dv),
    .ctrl(a_ctrl), .step(a_step), .fwd_en(a_fwd), .delta_req(a_req),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  dqn_update_sequencer #(.N_STEPS(15), .FWD_CYCLES(4), .DELTA_TIMEOUT(200)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .delta_valid(b_dv),
    .ctrl(b_ctrl), .step(b_step), .fwd_en(b_fwd), .delta_req(b_req),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  // outs = {ctrl[3:0], step[3:0], fwd_en, delta_req, busy, done, err}
  typedef struct packed {
    logic        start;
    logic        abort;
    logic        dv;
    logic [12:0] outs;
  } cyc_t;

  cyc_t        q[$];
  logic [12:0] log_q[$];
  bit          merr[2];
  int          dly[16];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [3:0]  pat[11] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h5, 4'h5, 4'h5, 4'h5, 4'h3, 4'h2, 4'h1};

  function automatic logic [12:0] ov(logic [3:0] c, logic [3:0] s, bit f, bit r, bit b, bit d, bit e);
    return {c, s, f, r, b, d, e};
  endfunction

  function automatic logic [12:0] idle_ov(bit e);
    return ov(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(bit st, bit ab, bit dv, logic [12:0] o);
    cyc_t e;
    e.start = st; e.abort = ab; e.dv = dv; e.outs = o;
    return e;
  endfunction

  // mode 0: quiet, 1: random start/delta_valid noise outside WAIT, 2: delta_valid held high
  function automatic bit st_n(int mode);
    return (mode == 1) ? rb() : 1'b0;
  endfunction

  function automatic bit dv_n(int mode);
    return (mode == 2) ? 1'b1 : ((mode == 1) ? rb() : 1'b0);
  endfunction

  function automatic logic [12:0] outs_of(int sel);
    if (sel == 0) return {a_ctrl, a_step, a_fwd, a_req, a_busy, a_done, a_err};
    return {b_ctrl, b_step, b_fwd, b_req, b_busy, b_done, b_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input bit st, input bit ab, input bit dv);
    a_start = (sel == 0) ? st : 1'b0;
    a_abort = (sel == 0) ? ab : 1'b0;
    a_dv    = (sel == 0) ? dv : 1'b0;
    b_start = (sel == 1) ? st : 1'b0;
    b_abort = (sel == 1) ? ab : 1'b0;
    b_dv    = (sel == 1) ? dv : 1'b0;
  endtask

  task automatic add_idle(input int sel, input int n);
    for (int i = 0; i < n; i++) q.push_back(mk(1'b0, rb(), rb(), idle_ov(merr[sel])));
  endtask

  // start together with abort: not accepted, err untouched
  task automatic add_start_abort(input int sel);
    q.push_back(mk(1'b1, 1'b1, rb(), idle_ov(merr[sel])));
  endtask

  // One run: dly[s-1] = cycles between delta_req rising and delta_valid, or -1 for
  // no answer (timeout). abort_at >= 1 cancels the run at that cycle of the run.
  task automatic add_run(input int sel, input int nsteps, input int fwd, input int tmo,
                         input int abort_at, input int mode);
    cyc_t r[$];
    bit   to;
    to = 1'b0;
    r.push_back(mk(1'b1, 1'b0, mode == 2, idle_ov(merr[sel])));
    for (int s = 1; s <= nsteps && !to; s++) begin
      for (int i = 0; i < fwd; i++)
        r.push_back(mk(st_n(mode), 1'b0, dv_n(mode), ov(4'h4, 4'(s), 1, 0, 1, 0, 0)));
      if (dly[s-1] < 0) begin
        for (int i = 0; i < tmo; i++)
          r.push_back(mk(st_n(mode), 1'b0, 1'b0, ov(4'h5, 4'(s), 0, 1, 1, 0, 0)));
        to = 1'b1;
      end else begin
        for (int i = 0; i <= dly[s-1]; i++)
          r.push_back(mk(st_n(mode), 1'b0, i == dly[s-1], ov(4'h5, 4'(s), 0, 1, 1, 0, 0)));
        r.push_back(mk(st_n(mode), 1'b0, dv_n(mode), ov(4'h3, 4'(s), 0, 0, 1, 0, 0)));
        r.push_back(mk(st_n(mode), 1'b0, dv_n(mode), ov(4'h2, 4'(s), 0, 0, 1, 0, 0)));
        r.push_back(mk(st_n(mode), 1'b0, dv_n(mode), ov(4'h1, 4'(s), 0, 0, 1, 0, 0)));
      end
    end
    if (!to) r.push_back(mk(st_n(mode), 1'b0, dv_n(mode), ov(4'h0, 4'h0, 0, 0, 1, 1, 0)));
    if (abort_at >= 1 && abort_at < r.size()) begin
      while (r.size() > abort_at + 1) void'(r.pop_back());
      r[abort_at].abort = 1'b1;
      merr[sel] = 1'b0;
    end else begin
      merr[sel] = to;
    end
    foreach (r[i]) q.push_back(r[i]);
  endtask

  // compare process: outputs checked every cycle, then that cycle's inputs driven
  task automatic run_q(input int sel, input int n);
    int k;
    cyc_t e;
    logic [12:0] a;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      e = q.pop_front();
      a = outs_of(sel);
      log_q.push_back(a);
      check($sformatf("cyc%0d dut%0d outs", cyc, sel), 32'(a), 32'(e.outs));
      drive(sel, e.start, e.abort, e.dv);
      @(posedge clk); #1;
      cyc++;
      k++;
    end
    drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int count_ctrl(logic [3:0] c);
    int n;
    n = 0;
    foreach (log_q[i]) if (log_q[i][12:9] == c) n++;
    return n;
  endfunction

  initial begin
    int mx;
    drive(0, 1'b0, 1'b0, 1'b0);
    merr[0] = 1'b0;
    merr[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outs dut0", 32'(outs_of(0)), 32'h0);
    check("reset outs dut1", 32'(outs_of(1)), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed: two iterations, delta_valid 3 cycles after delta_req
    add_idle(0, 2);
    run_q(0, -1);
    log_q.delete();
    dly[0] = 3; dly[1] = 3;
    add_run(0, 2, 4, 5, -1, 0);
    add_idle(0, 2);
    run_q(0, -1);
    for (int i = 0; i < 24; i++) begin
      logic [7:0] exp_cs;
      if (i == 0 || i == 23) exp_cs = 8'h00;
      else exp_cs = {pat[(i - 1) % 11], 4'((i - 1) / 11 + 1)};
      check($sformatf("nominal ctrl/step idx%0d", i), 32'(log_q[i][12:5]), 32'(exp_cs));
    end
    check("nominal done after second upd1", 32'({log_q[22][1], log_q[23][1]}), 32'h1);
    check("nominal idle after done", 32'(log_q[24]), 32'h0);

    // directed: timeout, then start+abort keeps err, then next start clears it
    log_q.delete();
    dly[0] = -1;
    add_run(0, 2, 4, 5, -1, 0);
    add_idle(0, 2);
    add_start_abort(0);
    add_idle(0, 1);
    run_q(0, -1);
    check("timeout wait length", 32'(count_ctrl(4'h5)), 32'd5);
    check("timeout idle with err", 32'(log_q[10]), 32'h001);
    check("start+abort keeps err", 32'(log_q[13]), 32'h001);
    log_q.delete();
    dly[0] = 0; dly[1] = 2;
    add_run(0, 2, 4, 5, -1, 0);
    add_idle(0, 1);
    run_q(0, -1);
    check("restart clears err", 32'(log_q[1]), 32'(ov(4'h4, 4'h1, 1, 0, 1, 0, 0)));

    // directed: abort during the UPD2 cycle of iteration 1
    log_q.delete();
    dly[0] = 3; dly[1] = 3;
    add_run(0, 2, 4, 5, 10, 0);
    add_idle(0, 3);
    run_q(0, -1);
    check("abort upd2 seen", 32'(log_q[10][12:9]), 32'h2);
    check("abort no upd1", 32'(count_ctrl(4'h1)), 32'd0);
    check("abort idle next", 32'(log_q[11]), 32'h0);

    // directed: start pulses during a run change nothing
    dly[0] = 1; dly[1] = 4;
    add_run(0, 2, 4, 5, -1, 1);
    add_idle(0, 2);
    run_q(0, -1);

    // directed: asynchronous reset in the middle of a WAIT cycle
    dly[0] = 3; dly[1] = 3;
    add_run(0, 2, 4, 5, -1, 0);
    run_q(0, 7);
    q.delete();
    check("pre-reset in wait", 32'(outs_of(0)), 32'(ov(4'h5, 4'h1, 0, 1, 1, 0, 0)));
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset outs", 32'(outs_of(0)), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    merr[0] = 1'b0;
    @(posedge clk); #1;
    log_q.delete();
    add_idle(0, 1);
    dly[0] = 2; dly[1] = 0;
    add_run(0, 2, 4, 5, -1, 0);
    add_idle(0, 1);
    run_q(0, -1);
    check("post-reset first step", 32'(log_q[2][8:5]), 32'h1);

    // random runs on A
    for (int r = 0; r < 25; r++) begin
      for (int s = 0; s < 2; s++)
        dly[s] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      add_idle(0, $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) add_start_abort(0);
      add_run(0, 2, 4, 5, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 28)) : -1,
              int'($urandom_range(0, 1)));
      add_idle(0, 1);
      run_q(0, -1);
    end

    // B: fifteen steps with delta_valid held high
    log_q.delete();
    for (int s = 0; s < 16; s++) dly[s] = 0;
    add_idle(1, 1);
    add_run(1, 15, 4, 200, -1, 2);
    add_idle(1, 2);
    run_q(1, -1);
    mx = 0;
    foreach (log_q[i]) if (int'(log_q[i][8:5]) > mx) mx = int'(log_q[i][8:5]);
    check("held dv max step", 32'(mx), 32'd15);
    check("held dv upd1 count", 32'(count_ctrl(4'h1)), 32'd15);
    check("held dv wait cycles", 32'(count_ctrl(4'h5)), 32'd15);

    // random runs on B
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 16; s++) dly[s] = int'($urandom_range(0, 6));
      add_idle(1, $urandom_range(0, 2));
      add_run(1, 15, 4, 200, ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 200)) : -1,
              int'($urandom_range(0, 1)));
      add_idle(1, 1);
      run_q(1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
